// File: rtl/cache_arb.sv
// cache_arb: shares one cache controller between an instruction-fetch port and a data port.
// Define CACHE_ARB_RR_EN for round-robin arbitration; default is fixed priority (data over instruction).
module cache_arb #(
    parameter int AW   = 32,
    parameter int DW   = 32,
    parameter int TOUT = 255,
    parameter int TW   = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] rdata,
    output logic          err,
    output logic          gnt,
    output logic          c_req,
    output logic          c_we,
    output logic [AW-1:0] c_addr,
    output logic [DW-1:0] c_wdata,
    input  logic [DW-1:0] c_rdata,
    input  logic          c_done
);

    // Handshake: a requester holds req and payload high until its one-cycle ack;
    // req still high in the cycle after ack is a fresh request. The controller
    // sees c_req high for the whole BUSY phase and answers with a c_done pulse.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [TW-1:0] WD_LAST = TW'(TOUT - 1);

    state_t        state, state_nxt;
    logic [TW-1:0] wd, wd_nxt;
    logic          gnt_nxt;
    logic          we_nxt;
    logic [AW-1:0] addr_nxt;
    logic [DW-1:0] wdata_nxt;
    logic [DW-1:0] rdata_nxt;
    logic          err_nxt;
    logic          pick_d;

`ifdef CACHE_ARB_RR_EN
    logic ptr, ptr_nxt;

    // On contention the port named by the pointer wins.
    assign pick_d = d_req & (~i_req | ptr);
`else
    assign pick_d = d_req;
`endif

    // Handshake outputs are decoded from registered state only.
    assign c_req = (state == BUSY);
    assign i_ack = (state == RESP) & ~gnt;
    assign d_ack = (state == RESP) & gnt;

    always_comb begin
        state_nxt = state;
        wd_nxt    = wd;
        gnt_nxt   = gnt;
        we_nxt    = c_we;
        addr_nxt  = c_addr;
        wdata_nxt = c_wdata;
        rdata_nxt = rdata;
        err_nxt   = err;
`ifdef CACHE_ARB_RR_EN
        ptr_nxt   = ptr;
`endif
        case (state)
            IDLE: begin
                if (i_req | d_req) begin
                    if (pick_d) begin
                        we_nxt    = d_we;
                        addr_nxt  = d_addr;
                        wdata_nxt = d_wdata;
                    end else begin
                        we_nxt    = 1'b0;
                        addr_nxt  = i_addr;
                        wdata_nxt = '0;
                    end
                    gnt_nxt   = pick_d;
                    wd_nxt    = '0;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                wd_nxt = wd + TW'(1);
                // A completion in the final watchdog cycle still counts as success.
                if (c_done) begin
                    rdata_nxt = c_rdata;
                    err_nxt   = 1'b0;
                    state_nxt = RESP;
                end else if (wd == WD_LAST) begin
                    rdata_nxt = '0;
                    err_nxt   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
`ifdef CACHE_ARB_RR_EN
                ptr_nxt   = ~gnt;
`endif
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            wd      <= '0;
            gnt     <= 1'b0;
            c_we    <= 1'b0;
            c_addr  <= '0;
            c_wdata <= '0;
            rdata   <= '0;
            err     <= 1'b0;
`ifdef CACHE_ARB_RR_EN
            ptr     <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            wd      <= wd_nxt;
            gnt     <= gnt_nxt;
            c_we    <= we_nxt;
            c_addr  <= addr_nxt;
            c_wdata <= wdata_nxt;
            rdata   <= rdata_nxt;
            err     <= err_nxt;
`ifdef CACHE_ARB_RR_EN
            ptr     <= ptr_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_cache_arb.sv
// Directed bench for cache_arb: a cache responder model plus a scoreboard of expected
// acknowledges (owner, err, rdata, and the latched controller request).
module tb_cache_arb;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int TOUT = 4;
    localparam int TW   = 8;
    localparam int EW   = 3 + AW + 2 * DW;

    logic          clk;
    logic          reset;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_ack;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ack;
    logic [DW-1:0] rdata;
    logic          err;
    logic          gnt;
    logic          c_req;
    logic          c_we;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata;
    logic [DW-1:0] c_rdata;
    logic          c_done;

    cache_arb #(.AW(AW), .DW(DW), .TOUT(TOUT), .TW(TW)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
        .rdata(rdata), .err(err), .gnt(gnt),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_rdata(c_rdata), .c_done(c_done)
    );

    // ---------------- clock / global time limit ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "time limit");
    end

    // ---------------- scoreboard state ----------------
    int            vectors = 0;
    int            miscompares = 0;
    logic [EW-1:0] exp_q[$];
    logic          ptr_m = 1'b0;

    // ---------------- cache responder ----------------
    // done_dly = n: c_done in the n-th BUSY cycle; 0 = never answer.
    int            done_dly = 1;
    logic          force_done = 1'b0;
    logic [DW-1:0] resp_data = '0;
    int            busy_n = 0;

    initial begin
        c_done  = 1'b0;
        c_rdata = 32'hBAD0_BAD0;
        forever begin
            @(negedge clk);
            busy_n  = c_req ? busy_n + 1 : 0;
            c_done  = (c_req && (busy_n == done_dly)) || force_done;
            c_rdata = c_done ? resp_data : 32'hBAD0_BAD0;
        end
    end

    // ---------------- driver / checker tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [EW-1:0] mk(input logic port, input logic e, input logic [DW-1:0] rd,
                                         input logic we, input logic [AW-1:0] a,
                                         input logic [DW-1:0] wd);
        return {port, e, rd, we, a, wd};
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, ".acks"}, 128'({i_ack, d_ack}), 128'(2'b00));
        chk({tag, ".c_req"}, 128'(c_req), 128'(1'b0));
    endtask

    // Steps until an ack (bounded), checking the latched controller request on the
    // first BUSY cycle and the acknowledge against the head of the scoreboard.
    task automatic wait_ack(input int lat, input string tag);
        logic [EW-1:0] e;
        int            n;
        bit            seen;
        e    = exp_q[0];
        n    = 0;
        seen = 0;
        do begin
            step();
            n++;
            if (c_req && !seen) begin
                seen = 1;
                chk({tag, ".c_we"}, 128'(c_we), 128'(e[AW+DW]));
                chk({tag, ".c_addr"}, 128'(c_addr), 128'(e[AW+DW-1:DW]));
                chk({tag, ".c_wdata"}, 128'(c_wdata), 128'(e[DW-1:0]));
            end
        end while (!(i_ack || d_ack) && n < 60);
        e = exp_q.pop_front();
        chk({tag, ".latency"}, 128'(n), 128'(lat));
        chk({tag, ".acks"}, 128'({i_ack, d_ack}), e[EW-1] ? 128'(2'b01) : 128'(2'b10));
        chk({tag, ".gnt"}, 128'(gnt), 128'(e[EW-1]));
        chk({tag, ".err"}, 128'(err), 128'(e[EW-2]));
        chk({tag, ".rdata"}, 128'(rdata), 128'(e[AW+2*DW:AW+DW+1]));
        ptr_m = ~e[EW-1];
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic pm;
        logic w;

        reset   = 1'b1;
        i_req   = 1'b0;
        i_addr  = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        step();
        step();
        chk("rst.c_req", 128'(c_req), 128'(1'b0));
        chk("rst.c_we", 128'(c_we), 128'(1'b0));
        chk("rst.c_addr", 128'(c_addr), 128'(0));
        chk("rst.c_wdata", 128'(c_wdata), 128'(0));
        chk("rst.acks", 128'({i_ack, d_ack}), 128'(2'b00));
        chk("rst.rdata", 128'(rdata), 128'(0));
        chk("rst.err", 128'(err), 128'(1'b0));
        chk("rst.gnt", 128'(gnt), 128'(1'b0));
        reset = 1'b0;
        ptr_m = 1'b0;
        step();

        // Instruction read, c_done three cycles after c_req rises (last watchdog cycle)
        resp_data = 32'hDEAD_BEEF;
        done_dly  = 4;
        i_addr    = 32'h100;
        i_req     = 1'b1;
        exp_q.push_back(mk(1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'h100, '0));
        wait_ack(5, "iread");
        i_req = 1'b0;
        step();
        chk_idle("iread.one");
        chk("iread.hold", 128'(rdata), 128'(32'hDEAD_BEEF));

        // Data write, c_done in the first BUSY cycle
        resp_data = '0;
        done_dly  = 1;
        d_we      = 1'b1;
        d_addr    = 32'h40;
        d_wdata   = 32'h1234_5678;
        d_req     = 1'b1;
        exp_q.push_back(mk(1'b1, 1'b0, '0, 1'b1, 32'h40, 32'h1234_5678));
        wait_ack(2, "dwrite");
        d_req = 1'b0;
        d_we  = 1'b0;
        step();
        chk_idle("dwrite.one");

        // Both ports held high for four back-to-back accesses
        resp_data = 32'h1111_2222;
        done_dly  = 1;
        i_addr    = 32'h200;
        d_addr    = 32'h300;
        d_wdata   = 32'h0;
        i_req     = 1'b1;
        d_req     = 1'b1;
        pm        = ptr_m;
        for (int k = 0; k < 4; k++) begin
`ifdef CACHE_ARB_RR_EN
            w = pm;
`else
            w = 1'b1;
`endif
            exp_q.push_back(mk(w, 1'b0, 32'h1111_2222, 1'b0, w ? 32'h300 : 32'h200, '0));
            pm = ~w;
        end
        for (int k = 0; k < 4; k++) begin
            wait_ack((k == 0) ? 2 : 3, $sformatf("dual%0d", k));
        end
        i_req = 1'b0;
        d_req = 1'b0;
        step();
        chk_idle("dual.end");

        // Timeout, then a late c_done in the following IDLE cycle
        done_dly = 0;
        i_addr   = 32'h404;
        i_req    = 1'b1;
        exp_q.push_back(mk(1'b0, 1'b1, '0, 1'b0, 32'h404, '0));
        wait_ack(TOUT + 1, "tout");
        i_req = 1'b0;
        step();
        resp_data  = 32'hCAFE_CAFE;
        force_done = 1'b1;
        step();
        force_done = 1'b0;
        chk_idle("late");
        chk("late.err", 128'(err), 128'(1'b1));
        chk("late.rdata", 128'(rdata), 128'(0));

        // Arbiter must still be idle: a fresh request completes at minimum latency
        done_dly = 1;
        i_addr   = 32'h500;
        i_req    = 1'b1;
        exp_q.push_back(mk(1'b0, 1'b0, 32'hCAFE_CAFE, 1'b0, 32'h500, '0));
        wait_ack(2, "post");
        i_req = 1'b0;
        step();

        // Reset in the middle of a data write
        done_dly = 0;
        d_we     = 1'b1;
        d_addr   = 32'h600;
        d_wdata  = 32'h77;
        d_req    = 1'b1;
        step();
        step();
        chk("mrst.busy", 128'(c_req), 128'(1'b1));
        reset = 1'b1;
        #1;
        chk("mrst.c_req", 128'(c_req), 128'(1'b0));
        chk("mrst.c_we", 128'(c_we), 128'(1'b0));
        chk("mrst.c_addr", 128'(c_addr), 128'(0));
        chk("mrst.c_wdata", 128'(c_wdata), 128'(0));
        chk("mrst.gnt", 128'(gnt), 128'(1'b0));
        chk("mrst.err", 128'(err), 128'(1'b0));
        chk("mrst.rdata", 128'(rdata), 128'(0));
        step();
        chk_idle("mrst.hold");
        d_req     = 1'b0;
        d_we      = 1'b0;
        ptr_m     = 1'b0;
        done_dly  = 2;
        resp_data = 32'h0F0F_0F0F;
        i_addr    = 32'h700;
        i_req     = 1'b1;
        exp_q.push_back(mk(1'b0, 1'b0, 32'h0F0F_0F0F, 1'b0, 32'h700, '0));
        reset = 1'b0;
        wait_ack(3, "mrst.post");
        i_req = 1'b0;
        step();
        chk_idle("mrst.end");

        chk("sb.empty", 128'(exp_q.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
